hazard_unit: RTL and testbench

- Per-operand data-hazard resolver for the execution stage. One instance is used per source register.
- Compares the operand's register id against the pending write-backs of younger pipeline stages. It then either forwards the newest ready value or requests a stall.
- Combinational forwarding path, plus clocked deadlock detection and optional statistics counters.

---
 rtl/hazard_unit.sv | 150 +++++++++++++++
 tb/tb_hazard_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - per-operand data-hazard resolver (forward / stall / deadlock detect)
//
// Purpose:
//   Resolves one source operand for the execution stage. It compares the
//   operand's register id with the pending write-backs of the younger stages.
//   It then forwards the newest ready value or requests a stall. A clocked
//   watchdog flags a stall that has lasted too long and keeps that flag set.
//   Optional statistics counters are built only when HAZARD_STATS_EN is
//   defined. Without that macro the counters read as 0 and no counter flops
//   exist.
//
// Ports:
//   clock              in   system clock
//   reset              in   asynchronous, active-high reset
//   programCounter     in   PC of the instruction owning this operand
//   registerId         in   source register id read by the instruction
//   originalData       in   value read from the register file
//   stallCount         in   consecutive cycles the stage has already stalled
//   dataFromNextStages in   NUM_STAGES slots of {registerId, dataReady, data};
//                           slot 0 (LSBs) is the nearest stage
//   forwardedData      out  resolved operand value (combinational)
//   stall              out  operand not yet available (combinational)
//   deadlock           out  sticky: stall persisted to STALL_LIMIT
//   deadlockPc         out  programCounter captured when deadlock first set
//   stallCycles        out  number of stalled edges (saturating, optional)
//   forwardHits        out  number of ready-forward edges (saturating, optional)

module hazard_unit #(
  parameter int          DATA_W      = 32,
  parameter int          REG_ID_W    = 5,
  parameter int          PC_W        = 32,
  parameter int          NUM_STAGES  = 3,
  parameter int          STALL_CNT_W = 4,
  parameter int unsigned STALL_LIMIT = 8,
  parameter int          CNT_W       = 16
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic [PC_W-1:0]                             programCounter,
  input  logic [REG_ID_W-1:0]                         registerId,
  input  logic [DATA_W-1:0]                           originalData,
  input  logic [STALL_CNT_W-1:0]                      stallCount,
  input  logic [NUM_STAGES*(REG_ID_W+1+DATA_W)-1:0]   dataFromNextStages,
  output logic [DATA_W-1:0]                           forwardedData,
  output logic                                        stall,
  output logic                                        deadlock,
  output logic [PC_W-1:0]                             deadlockPc,
  output logic [CNT_W-1:0]                            stallCycles,
  output logic [CNT_W-1:0]                            forwardHits
);

  localparam int E = REG_ID_W + 1 + DATA_W;

  logic [REG_ID_W-1:0] w_slot_id   [NUM_STAGES];
  logic                w_slot_rdy  [NUM_STAGES];
  logic [DATA_W-1:0]   w_slot_data [NUM_STAGES];

  genvar g;
  generate
    for (g = 0; g < NUM_STAGES; g++) begin : g_slot
      assign w_slot_id[g]   = dataFromNextStages[g*E+DATA_W+1 +: REG_ID_W];
      assign w_slot_rdy[g]  = dataFromNextStages[g*E+DATA_W];
      assign w_slot_data[g] = dataFromNextStages[g*E +: DATA_W];
    end
  endgenerate

  logic              w_found;
  logic              w_stall;
  logic [DATA_W-1:0] w_fwd;

  // The first matching slot decides the outcome, even when it is not ready.
  // A not-ready near slot hides any older, ready copy further down.
  // Register 0 never matches. Empty slots are also encoded with id 0.
  always_comb begin
    w_found = 1'b0;
    w_stall = 1'b0;
    w_fwd   = originalData;
    if (registerId != '0) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (!w_found && (w_slot_id[i] == registerId)) begin
          w_found = 1'b1;
          if (w_slot_rdy[i]) begin
            w_fwd = w_slot_data[i];
          end else begin
            w_stall = 1'b1;
          end
        end
      end
    end
  end

  assign forwardedData = w_fwd;
  assign stall         = w_stall;

  // Widen before comparing. A limit above the stallCount range can then
  // never be reached, and the deadlock flag stays clear.
  logic [31:0] w_stall_cnt_ext;
  logic        w_limit_reached;

  assign w_stall_cnt_ext = 32'(stallCount);
  assign w_limit_reached = (w_stall_cnt_ext >= STALL_LIMIT);

  logic            r_deadlock;
  logic [PC_W-1:0] r_deadlock_pc;

  // deadlockPc is loaded only on the 0->1 transition. It therefore names the
  // instruction that first hung, not a later one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_deadlock    <= 1'b0;
      r_deadlock_pc <= '0;
    end else if (w_stall && w_limit_reached && !r_deadlock) begin
      r_deadlock    <= 1'b1;
      r_deadlock_pc <= programCounter;
    end
  end

  assign deadlock   = r_deadlock;
  assign deadlockPc = r_deadlock_pc;

`ifdef HAZARD_STATS_EN
  logic             w_hit;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_forward_hits;

  assign w_hit = w_found && !w_stall;

  // Both counters stop at all-ones rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_forward_hits <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_hit && (r_forward_hits != '1)) begin
        r_forward_hits <= r_forward_hits + 1'b1;
      end
    end
  end

  assign stallCycles = r_stall_cycles;
  assign forwardHits = r_forward_hits;
`else
  assign stallCycles = '0;
  assign forwardHits = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit (vectors, corner sequences, random vs model)

module tb_hazard_unit;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int PW  = 32;
  localparam int NS  = 3;
  localparam int SW  = 4;
  localparam int LIM = 8;
  localparam int CW  = 16;
  localparam int CWS = 2;
  localparam int E   = RW + 1 + DW;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [PW-1:0]   pc    = '0;
  logic [RW-1:0]   rid   = '0;
  logic [DW-1:0]   orig  = '0;
  logic [SW-1:0]   sc    = '0;
  logic [NS*E-1:0] slots = '0;

  logic [DW-1:0]  fwd_o,   fwd_s;
  logic           stall_o, stall_s;
  logic           dl_o,    dl_s;
  logic [PW-1:0]  dpc_o,   dpc_s;
  logic [CW-1:0]  scy_o,   fh_o;
  logic [CWS-1:0] scy_s,   fh_s;

  hazard_unit #(.DATA_W(DW), .REG_ID_W(RW), .PC_W(PW), .NUM_STAGES(NS),
                .STALL_CNT_W(SW), .STALL_LIMIT(LIM), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .programCounter(pc), .registerId(rid),
    .originalData(orig), .stallCount(sc), .dataFromNextStages(slots),
    .forwardedData(fwd_o), .stall(stall_o), .deadlock(dl_o), .deadlockPc(dpc_o),
    .stallCycles(scy_o), .forwardHits(fh_o));

  hazard_unit #(.DATA_W(DW), .REG_ID_W(RW), .PC_W(PW), .NUM_STAGES(NS),
                .STALL_CNT_W(SW), .STALL_LIMIT(LIM), .CNT_W(CWS)) dut_s (
    .clock(clock), .reset(reset), .programCounter(pc), .registerId(rid),
    .originalData(orig), .stallCount(sc), .dataFromNextStages(slots),
    .forwardedData(fwd_s), .stall(stall_s), .deadlock(dl_s), .deadlockPc(dpc_s),
    .stallCycles(scy_s), .forwardHits(fh_s));

  always #5 clock = ~clock;

  typedef struct {
    logic [RW-1:0] id;
    logic          rdy;
    logic [DW-1:0] data;
  } slot_t;

  typedef struct {
    logic [RW-1:0] rid;
    logic [DW-1:0] orig;
    slot_t         s0, s1, s2;
    logic          stall;
    logic [DW-1:0] fwd;
  } vec_t;

  slot_t cur [NS];
  vec_t  tbl [7];

  int errors = 0;
  int checks = 0;

  logic          exp_dl;
  logic [PW-1:0] exp_dpc;
  int            exp_sc, exp_fh, exp_sc_s, exp_fh_s;

  function automatic slot_t mk(input logic [RW-1:0] id, input logic rdy, input logic [DW-1:0] d);
    slot_t s;
    s.id = id; s.rdy = rdy; s.data = d;
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: gather every slot whose id matches; the lowest-index one rules.
  task automatic ref_eval(output logic st, output logic [DW-1:0] fw, output logic ht);
    int q[$];
    st = 1'b0; ht = 1'b0; fw = orig;
    if (rid != 0) begin
      for (int i = 0; i < NS; i++) if (cur[i].id == rid) q.push_back(i);
      if (q.size() > 0) begin
        if (cur[q[0]].rdy) begin fw = cur[q[0]].data; ht = 1'b1; end
        else st = 1'b1;
      end
    end
  endtask

  function automatic int sat_inc(input int v, input int w);
    return (v == (1 << w) - 1) ? v : v + 1;
  endfunction

  task automatic clear_model();
    exp_dl = 1'b0; exp_dpc = '0;
    exp_sc = 0; exp_fh = 0; exp_sc_s = 0; exp_fh_s = 0;
  endtask

  task automatic drive_check(input string tag);
    logic st, ht;
    logic [DW-1:0] fw;
    for (int i = 0; i < NS; i++) slots[i*E +: E] = {cur[i].id, cur[i].rdy, cur[i].data};
    #1;
    ref_eval(st, fw, ht);
    chk({tag, " stall"}, 64'(stall_o), 64'(st));
    chk({tag, " fwd"},   64'(fwd_o),   64'(fw));
  endtask

  task automatic check_seq(input string tag);
    chk({tag, " deadlock"},   64'(dl_o),  64'(exp_dl));
    chk({tag, " deadlockPc"}, 64'(dpc_o), 64'(exp_dpc));
    chk({tag, " stallCycles"}, 64'(scy_o), STATS ? 64'(exp_sc)   : 64'(0));
    chk({tag, " forwardHits"}, 64'(fh_o),  STATS ? 64'(exp_fh)   : 64'(0));
    chk({tag, " stallCyc_s"},  64'(scy_s), STATS ? 64'(exp_sc_s) : 64'(0));
    chk({tag, " fwdHits_s"},   64'(fh_s),  STATS ? 64'(exp_fh_s) : 64'(0));
  endtask

  task automatic step(input string tag);
    logic st, ht;
    logic [DW-1:0] fw;
    ref_eval(st, fw, ht);
    if (st && (int'(sc) >= LIM) && !exp_dl) begin exp_dl = 1'b1; exp_dpc = pc; end
    if (st) begin exp_sc = sat_inc(exp_sc, CW); exp_sc_s = sat_inc(exp_sc_s, CWS); end
    if (ht) begin exp_fh = sat_inc(exp_fh, CW); exp_fh_s = sat_inc(exp_fh_s, CWS); end
    @(posedge clock);
    #1;
    check_seq(tag);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 clear_model();
    check_seq("reset");
    #2 reset = 1'b0;
  endtask

  task automatic empty_slots();
    for (int i = 0; i < NS; i++) cur[i] = mk('0, 1'b1, '0);
  endtask

  initial begin
    slot_t e;
    e = mk('0, 1'b1, '0);
    tbl[0] = '{5'd5,  32'h11, mk(5, 1, 32'hAA), mk(5, 1, 32'hBB), e, 1'b0, 32'hAA};
    tbl[1] = '{5'd5,  32'h11, mk(3, 1, 32'hAA), mk(5, 1, 32'hBB), e, 1'b0, 32'hBB};
    tbl[2] = '{5'd5,  32'h11, mk(3, 1, 32'hAA), mk(7, 1, 32'hBB), e, 1'b0, 32'h11};
    tbl[3] = '{5'd5,  32'h11, mk(5, 0, 32'hCC), mk(5, 1, 32'hBB), e, 1'b1, 32'h11};
    tbl[4] = '{5'd0,  32'h00, mk(0, 1, 32'hFF), e, e, 1'b0, 32'h00};
    tbl[5] = '{5'd5,  32'h22, mk(1, 1, 32'h1), mk(2, 0, 32'h2), mk(5, 1, 32'hDD), 1'b0, 32'hDD};
    tbl[6] = '{5'd31, 32'h33, e, mk(31, 0, 32'h7), mk(31, 1, 32'hEE), 1'b1, 32'h33};

    clear_model();
    empty_slots();
    #3;
    check_seq("por");
    #9 reset = 1'b0;

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      rid = tbl[i].rid; orig = tbl[i].orig; sc = '0;
      cur[0] = tbl[i].s0; cur[1] = tbl[i].s1; cur[2] = tbl[i].s2;
      drive_check($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d hand stall", i), 64'(stall_o), 64'(tbl[i].stall));
      chk($sformatf("tbl%0d hand fwd", i),   64'(fwd_o),   64'(tbl[i].fwd));
      step($sformatf("tbl%0d", i));
    end

    // Deadlock: hold stall, ramp stallCount to the limit
    do_reset();
    empty_slots();
    rid = 5; orig = 32'h11; pc = 32'h40;
    cur[0] = mk(5, 0, 32'h99);
    for (int s = 0; s <= 8; s++) begin
      sc = SW'(s);
      drive_check("dl ramp");
      step("dl ramp");
      chk($sformatf("dl hand sc=%0d", s), 64'(dl_o), 64'(s >= 8));
    end
    chk("dl hand pc", 64'(dpc_o), 64'h40);
    pc = 32'h44; sc = 4'd9;
    drive_check("dl hold");
    step("dl hold");
    chk("dl pc kept", 64'(dpc_o), 64'h40);
    // Async reset between edges; comb path keeps following inputs.
    #2 reset = 1'b1;
    #1;
    chk("async rst deadlock", 64'(dl_o), 64'h0);
    chk("async rst pc",       64'(dpc_o), 64'h0);
    chk("rst comb stall",     64'(stall_o), 64'h1);
    chk("rst comb fwd",       64'(fwd_o), 64'h11);
    clear_model();
    #2 reset = 1'b0;

    // Statistics and saturation
    do_reset();
    sc = '0;
    for (int i = 0; i < 3; i++) begin drive_check("st stall"); step("st stall"); end
    cur[0] = mk(5, 1, 32'hAA);
    for (int i = 0; i < 2; i++) begin drive_check("st fwd"); step("st fwd"); end
    chk("st hand stallCycles", 64'(scy_o), STATS ? 64'd3 : 64'd0);
    chk("st hand forwardHits", 64'(fh_o),  STATS ? 64'd2 : 64'd0);
    cur[0] = mk(5, 0, 32'hAA);
    for (int i = 0; i < 2; i++) begin drive_check("sat stall"); step("sat stall"); end
    cur[0] = mk(5, 1, 32'hAA);
    for (int i = 0; i < 2; i++) begin drive_check("sat fwd"); step("sat fwd"); end
    chk("sat hand stall_s", 64'(scy_s), STATS ? 64'd3 : 64'd0);
    chk("sat hand hits_s",  64'(fh_s),  STATS ? 64'd3 : 64'd0);
    chk("sat fwd_s",        64'(fwd_s), 64'hAA);
    chk("sat stall_s",      64'(stall_s), 64'h0);
    chk("sat dl_s",         64'(dl_s), 64'(dl_o));
    chk("sat dpc_s",        64'(dpc_s), 64'(dpc_o));

    // Random against the model
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 99) do_reset();
      pc   = $urandom;
      rid  = RW'($urandom_range(0, 7));
      orig = $urandom;
      sc   = SW'($urandom_range(0, 15));
      for (int i = 0; i < NS; i++) begin
        if ($urandom_range(0, 4) == 0) cur[i] = mk('0, 1'b1, '0);
        else cur[i] = mk(RW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
      end
      drive_check("rnd");
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
